// File: rtl/input_decoder_pkg.sv
// Shared keypad-input codes and calculator token encodings.
// Used by the keypad decoder and the downstream calculator core.
package input_decoder_pkg;

  localparam int IC_N = 5;
  localparam int TK_N = 3;

  typedef logic [IC_N-1:0] ic_t;
  typedef logic [TK_N-1:0] tk_t;

  localparam ic_t IC_NONE = 5'd0;
  localparam ic_t IC_OPAD = 5'd1;
  localparam ic_t IC_OPSB = 5'd2;
  localparam ic_t IC_OPAN = 5'd3;
  localparam ic_t IC_OPOR = 5'd4;
  localparam ic_t IC_CTOK = 5'd5;
  localparam ic_t IC_NUM0 = 5'd16;
  localparam ic_t IC_NUM9 = 5'd25;

  localparam tk_t TK_NUM  = 3'd0;
  localparam tk_t TK_OPAD = 3'd1;
  localparam tk_t TK_OPSB = 3'd2;
  localparam tk_t TK_OPAN = 3'd3;
  localparam tk_t TK_OPOR = 3'd4;
  localparam tk_t TK_CTOK = 3'd5;

  function automatic tk_t ic_to_tk(input ic_t c);
    tk_t t;
    t = TK_CTOK;
    case (c)
      IC_OPAD: t = TK_OPAD;
      IC_OPSB: t = TK_OPSB;
      IC_OPAN: t = TK_OPAN;
      IC_OPOR: t = TK_OPOR;
      default: t = TK_CTOK;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/input_decoder_fifo.sv
// Token FIFO: up to two pushes and one pop per cycle.
// Empty head reads as all-zero payload.
module input_token_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 19,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    push_cnt_i,
  input  logic [DW-1:0] push0_i,
  input  logic [DW-1:0] push1_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [CW-1:0] free_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, w1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop     = pop_i & (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem[rptr_q] : '0;
  assign free_o  = CW'(DEPTH) - cnt_q;
  assign w1      = inc(wptr_q);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push_cnt_i) - CW'(pop);
    if (push_cnt_i == 2'd1) wptr_d = w1;
    if (push_cnt_i == 2'd2) wptr_d = inc(w1);
    if (pop) rptr_d = inc(rptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage carries no reset; the empty head is masked above.
  always_ff @(posedge clk) begin
    if (push_cnt_i != 2'd0) mem[wptr_q] <= push0_i;
    if (push_cnt_i == 2'd2) mem[w1] <= push1_i;
  end

endmodule

// File: rtl/input_decoder.sv
// Keypad command decoder: digits to operands, operators to tokens.
// Optional echo outputs under INPUT_DECODER_ECHO_EN.
module input_decoder
  import input_decoder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [IC_N-1:0]  cmd,
  output logic             tk_valid,
  input  logic             tk_ready,
  output logic [TK_N-1:0]  tk_type,
  output logic [WIDTH-1:0] tk_value,
  output logic             ovf,
  output logic             drop
`ifdef INPUT_DECODER_ECHO_EN
  ,
  output logic [WIDTH-1:0] echo,
  output logic             echo_active
`endif
);

  localparam int unsigned DW = TK_N + WIDTH;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [WIDTH+3:0] TEN  = (WIDTH + 4)'(10);
  localparam logic [WIDTH+3:0] MAXV = {4'b0, {WIDTH{1'b1}}};

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, base;
  logic             ovf_q, ovf_d, drop_q, drop_d;
  logic [WIDTH+3:0] prod;
  logic [3:0]       dig;
  logic             is_dig, is_op, pop;
  logic [CW:0]      avail, need;
  logic [1:0]       push_cnt;
  logic [DW-1:0]    push0, push1, rd;
  logic [CW-1:0]    free;
  tk_t              op_tk;

  assign is_dig = (cmd >= IC_NUM0) && (cmd <= IC_NUM9);
  assign is_op  = (cmd >= IC_OPAD) && (cmd <= IC_CTOK);
  assign dig    = 4'(cmd - IC_NUM0);
  assign op_tk  = ic_to_tk(cmd);
  assign pop    = tk_valid & tk_ready;
  // A same-cycle pop frees a slot for this cycle's push.
  assign avail  = {1'b0, free} + (CW + 1)'(pop);
  assign need   = (state_q == ACCUM) ? (CW + 1)'(2) : (CW + 1)'(1);
  assign base   = (state_q == ACCUM) ? acc_q : '0;
  assign prod   = {4'b0, base} * TEN + (WIDTH + 4)'(dig);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    drop_d   = 1'b0;
    push_cnt = 2'd0;
    push0    = {op_tk, {WIDTH{1'b0}}};
    push1    = {op_tk, {WIDTH{1'b0}}};
    unique case (1'b1)
      is_dig: begin
        if (prod > MAXV) begin
          ovf_d = 1'b1;
        end else begin
          acc_d   = prod[WIDTH-1:0];
          state_d = ACCUM;
        end
      end
      is_op: begin
        if (avail < need) begin
          drop_d = 1'b1;
        end else if (state_q == ACCUM) begin
          push_cnt = 2'd2;
          push0    = {TK_NUM, acc_q};
          acc_d    = '0;
          ovf_d    = 1'b0;
          state_d  = IDLE;
        end else begin
          push_cnt = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  input_token_fifo #(
    .DEPTH(DEPTH),
    .DW   (DW),
    .CW   (CW)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (Reset),
    .push_cnt_i(push_cnt),
    .push0_i   (push0),
    .push1_i   (push1),
    .pop_i     (pop),
    .valid_o   (tk_valid),
    .data_o    (rd),
    .free_o    (free)
  );

  assign tk_type  = rd[DW-1 -: TK_N];
  assign tk_value = rd[WIDTH-1:0];
  assign ovf      = ovf_q;
  assign drop     = drop_q;

`ifdef INPUT_DECODER_ECHO_EN
  assign echo        = acc_q;
  assign echo_active = (state_q == ACCUM);
`endif

endmodule

// File: tb/tb_input_decoder.sv
// Directed checks for input_decoder at WIDTH=16, DEPTH=2.
// Echo checks run when INPUT_DECODER_ECHO_EN is defined.
module tb_input_decoder;
  import input_decoder_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  cmd;
  logic        tk_valid, tk_ready;
  logic [2:0]  tk_type;
  logic [15:0] tk_value;
  logic        ovf, drop;
`ifdef INPUT_DECODER_ECHO_EN
  logic [15:0] echo;
  logic        echo_active;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  input_decoder #(.WIDTH(16), .DEPTH(2)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .cmd     (cmd),
    .tk_valid(tk_valid),
    .tk_ready(tk_ready),
    .tk_type (tk_type),
    .tk_value(tk_value),
    .ovf     (ovf),
    .drop    (drop)
`ifdef INPUT_DECODER_ECHO_EN
    ,
    .echo       (echo),
    .echo_active(echo_active)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input ic_t c);
    cmd = c;
    tick();
    cmd = IC_NONE;
  endtask

  task automatic digit(input int d);
    send(ic_t'(IC_NUM0 + d));
  endtask

  task automatic tok(input string tag, input logic [2:0] t,
                     input logic [15:0] v);
    check({tag, ".valid"}, tk_valid, 1);
    check({tag, ".type"}, tk_type, t);
    check({tag, ".value"}, tk_value, v);
  endtask

  initial begin
    Reset    = 1'b0;
    cmd      = IC_NONE;
    tk_ready = 1'b0;
    #1;
    check("rst.valid", tk_valid, 0);
    check("rst.type", tk_type, TK_NUM);
    check("rst.value", tk_value, 0);
    check("rst.ovf", ovf, 0);
    check("rst.drop", drop, 0);
    tick();
    Reset = 1'b1;

    // digits then operator
    tk_ready = 1'b1;
    digit(1);
    digit(2);
    digit(3);
    send(5'd31);
    check("unlisted.drop", drop, 0);
    send(IC_OPAD);
    check("t1.drop", drop, 0);
    tok("t1.num", TK_NUM, 16'd123);
    tick();
    tok("t1.op", TK_OPAD, 16'd0);
    tick();
    check("t1.empty", tk_valid, 0);

    // overflow
    digit(6);
    digit(5);
    digit(5);
    digit(3);
    digit(5);
    check("t2.noovf", ovf, 0);
    digit(9);
    check("t2.ovf", ovf, 1);
    check("t2.acc", dut.acc_q, 65535);
    send(IC_CTOK);
    tok("t2.num", TK_NUM, 16'd65535);
    check("t2.ovfclr", ovf, 0);
    tick();
    tok("t2.op", TK_CTOK, 16'd0);
    tick();
    check("t2.empty", tk_valid, 0);

    // backpressure and drop
    tk_ready = 1'b0;
    digit(7);
    send(IC_OPSB);
    tok("t3.head", TK_NUM, 16'd7);
    send(IC_OPAN);
    check("t3.drop", drop, 1);
    tok("t3.hold", TK_NUM, 16'd7);
    digit(3);
    check("t3.dropclr", drop, 0);
    send(IC_OPOR);
    check("t3.drop2", drop, 1);
    check("t3.acc", dut.acc_q, 3);
    tk_ready = 1'b1;
    tick();
    tok("t3.op", TK_OPSB, 16'd0);
    tick();
    check("t3.empty", tk_valid, 0);
    send(IC_CTOK);
    tok("t3.num3", TK_NUM, 16'd3);
    tick();
    tok("t3.ctok", TK_CTOK, 16'd0);
    tick();
    check("t3.empty2", tk_valid, 0);

    // push of two with one free slot plus a pop
    tk_ready = 1'b0;
    send(IC_CTOK);
    digit(4);
    tk_ready = 1'b1;
    send(IC_OPOR);
    check("t4.drop", drop, 0);
    tok("t4.num", TK_NUM, 16'd4);
    tick();
    tok("t4.op", TK_OPOR, 16'd0);
    tick();
    check("t4.empty", tk_valid, 0);

    // reset mid-entry
    tk_ready = 1'b0;
    send(IC_CTOK);
    digit(9);
    digit(8);
    check("t5.pre", tk_valid, 1);
    Reset = 1'b0;
    #1;
    check("t5.valid", tk_valid, 0);
    check("t5.acc", dut.acc_q, 0);
    check("t5.type", tk_type, TK_NUM);
    tick();
    Reset = 1'b1;
    send(IC_CTOK);
    tok("t5.ctok", TK_CTOK, 16'd0);
    tk_ready = 1'b1;
    tick();
    check("t5.empty", tk_valid, 0);

`ifdef INPUT_DECODER_ECHO_EN
    digit(4);
    digit(2);
    check("echo.val", echo, 42);
    check("echo.act", echo_active, 1);
    send(IC_OPAD);
    check("echo.idle", echo_active, 0);
    tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
